video_frame_fetch: RTL and testbench

//  Parametrised successor to the fixed 960x540 DMA master. Fetches one frame per VSync from DDR3

---
 rtl/video_pkg.sv | 21 ++
 rtl/video_burst_credit.sv | 37 +++
 rtl/video_frame_fetch.sv | 158 +++++++++++++++
 tb/tb_video_frame_fetch.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video frame fetch block: FSM encoding,
// common frame geometries and a small arithmetic helper.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam int H_WORDS_540  = 960;
  localparam int V_LINES_540  = 540;
  localparam int H_WORDS_1080 = 1920;
  localparam int V_LINES_1080 = 1080;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/video_burst_credit.sv
// Tracks words requested from memory but not yet returned, and decides whether
// a burst of 'len' words still fits in the pixel FIFO once everything in
// flight has landed.
module video_burst_credit #(
  parameter int FIFO_DEPTH = 512,
  parameter int FIFO_AW    = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FIFO_AW-1:0] fifo_used,
  input  logic [7:0]         len,
  input  logic               issue_ack,
  input  logic               rd_valid,
  output logic [FIFO_AW:0]   outstanding,
  output logic               credit_ok
);

  // Wide enough that fill + in-flight + a full burst can never wrap.
  localparam int SW = FIFO_AW + 10;

  logic [SW-1:0] demand;

  assign demand    = SW'(fifo_used) + SW'(outstanding) + SW'(len);
  assign credit_ok = (demand <= SW'(FIFO_DEPTH));

  // Accepted bursts add their length; every returned word retires one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding
                     + (issue_ack ? (FIFO_AW+1)'(len) : '0)
                     - (rd_valid  ? (FIFO_AW+1)'(1)   : '0);
    end
  end

endmodule

// File: rtl/video_frame_fetch.sv
// Frame fetch DMA master: on each VSync reads one frame from memory, line by
// line, in bursts that never cross a line and never overrun the pixel FIFO.
//
// state | meaning
// IDLE  | nothing armed; waits for start or continuous re-arm
// ARMED | frame armed; waits for vsync_edge
// ISSUE | issuing bursts for the current frame
// DRAIN | all bursts accepted; waiting for the last words to return
module video_frame_fetch
  import video_pkg::*;
#(
  parameter int H_WORDS    = 960,
  parameter int V_LINES    = 540,
  parameter int BURST_MAX  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int FIFO_AW    = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        cfg_base_addr,
  input  logic [15:0]        cfg_stride,
  input  logic               cfg_enable,
  input  logic               cfg_continuous,
  input  logic               start,
  input  logic               vsync_edge,
  input  logic               m_waitrequest,
  input  logic [31:0]        m_readdata,
  input  logic               m_readdatavalid,
  output logic [31:0]        m_address,
  output logic               m_read,
  output logic [7:0]         m_burstcount,
  input  logic [FIFO_AW-1:0] fifo_used,
  output logic               fifo_wr_en,
  output logic [31:0]        fifo_wr_data,
  output logic               busy,
  output logic               frame_done,
  output logic               late_frame,
  output logic [15:0]        frame_count
);

  localparam int WW = $clog2(H_WORDS + 1);
  localparam int LW = (V_LINES > 1) ? $clog2(V_LINES + 1) : 1;

  fetch_state_t      state;
  logic [31:0]       line_base;
  logic [15:0]       stride;
  logic [WW-1:0]     word_idx;
  logic [LW-1:0]     line_idx;

  logic [WW-1:0]     remain;
  logic [7:0]        len;
  logic [7:0]        credit_len;
  logic              accept;
  logic              rd_valid;
  logic              line_end;
  logic              last_line;
  logic              credit_ok;
  logic [FIFO_AW:0]  outstanding;

  assign remain     = WW'(H_WORDS) - word_idx;
  assign len        = 8'(min_u32(32'(remain), 32'(BURST_MAX)));
  // While a request is pending its own length is what gets booked on acceptance.
  assign credit_len = m_read ? m_burstcount : len;
  assign accept     = m_read && !m_waitrequest;
  // Data returning outside a frame (e.g. after a reset mid-frame) is dropped.
  assign rd_valid   = m_readdatavalid && busy;
  assign line_end   = (32'(word_idx) + 32'(m_burstcount)) == 32'(H_WORDS);
  assign last_line  = (line_idx == LW'(V_LINES - 1));

  assign fifo_wr_en   = rd_valid;
  assign fifo_wr_data = m_readdata;

  video_burst_credit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_credit (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo_used   (fifo_used),
    .len         (credit_len),
    .issue_ack   (accept),
    .rd_valid    (rd_valid),
    .outstanding (outstanding),
    .credit_ok   (credit_ok)
  );

  // Frame sequencing, burst issue and status outputs, all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      line_base    <= '0;
      stride       <= '0;
      word_idx     <= '0;
      line_idx     <= '0;
      m_read       <= 1'b0;
      m_address    <= '0;
      m_burstcount <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      late_frame   <= 1'b0;
      frame_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      late_frame <= vsync_edge && busy;
      case (state)
        ST_IDLE: begin
          if (start || (cfg_continuous && cfg_enable)) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (vsync_edge) begin
            line_base <= cfg_base_addr;
            stride    <= cfg_stride;
            word_idx  <= '0;
            line_idx  <= '0;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
            // Nothing is in flight here and word_idx is already 0, so the
            // first burst can be requested without waiting a cycle.
            if (credit_ok) begin
              m_read       <= 1'b1;
              m_address    <= cfg_base_addr;
              m_burstcount <= len;
            end
          end
        end
        ST_ISSUE: begin
          if (m_read) begin
            if (!m_waitrequest) begin
              m_read <= 1'b0;
              if (line_end) begin
                word_idx  <= '0;
                line_base <= line_base + {16'h0000, stride};
                line_idx  <= line_idx + 1'b1;
                if (last_line) state <= ST_DRAIN;
              end else begin
                word_idx <= word_idx + WW'(m_burstcount);
              end
            end
          end else if (credit_ok) begin
            m_read       <= 1'b1;
            m_address    <= line_base + 32'({word_idx, 2'b00});
            m_burstcount <= len;
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            frame_done  <= 1'b1;
            busy        <= 1'b0;
            frame_count <= frame_count + 16'd1;
            state       <= (cfg_continuous && cfg_enable) ? ST_ARMED : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_fetch.sv
// Bench for video_frame_fetch: 20x4 frame, bursts of up to 8 words.
// Expected bursts and frame completions are queued when a frame is launched;
// the memory/monitor process checks them as the DUT presents them.
module tb_video_frame_fetch;

  localparam int H  = 20;
  localparam int V  = 4;
  localparam int BM = 8;
  localparam int FD = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   cfg_base_addr = '0;
  logic [15:0]   cfg_stride = '0;
  logic          cfg_enable = 1'b1;
  logic          cfg_continuous = 1'b0;
  logic          start = 1'b0;
  logic          vsync_edge = 1'b0;
  logic          m_waitrequest = 1'b0;
  logic [31:0]   m_readdata = '0;
  logic          m_readdatavalid = 1'b0;
  logic [31:0]   m_address;
  logic          m_read;
  logic [7:0]    m_burstcount;
  logic [AW-1:0] fifo_used;
  logic          fifo_wr_en;
  logic [31:0]   fifo_wr_data;
  logic          busy;
  logic          frame_done;
  logic          late_frame;
  logic [15:0]   frame_count;

  typedef struct {logic [31:0] addr; logic [7:0] len;} burst_t;
  typedef struct {int due; logic [31:0] data;} word_t;

  burst_t      exp_burst[$];
  word_t       rd_q[$];
  logic [31:0] exp_data[$];
  logic [15:0] exp_done[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, lat = 1, acc_cnt = 0, done_seen = 0, late_seen = 0;
  int frame_words = 0, level = 0, max_level = 0, out_model = 0, max_out = 0;
  bit wr_rand = 1'b0;
  int fu_mode = 0;
  logic [AW-1:0] fu_force = '0;

  assign fifo_used = (fu_mode == 1) ? fu_force : (fu_mode == 2) ? AW'(level) : '0;

  video_frame_fetch #(
    .H_WORDS(H), .V_LINES(V), .BURST_MAX(BM), .FIFO_DEPTH(FD), .FIFO_AW(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .start(start), .vsync_edge(vsync_edge),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_burstcount(m_burstcount),
    .fifo_used(fifo_used), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .frame_done(frame_done), .late_frame(late_frame),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and monitor: checks what the DUT presented this cycle,
  // then drives waitrequest / read data for the next edge.
  always @(negedge clk) begin : mem_mon
    burst_t eb;
    word_t w;
    logic [31:0] ed;
    logic [15:0] ef;
    if (!reset_n) begin
      m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
      rd_q.delete(); exp_data.delete(); exp_burst.delete(); exp_done.delete();
      out_model = 0; frame_words = 0; level = 0;
    end else begin
      if (frame_done) begin
        done_seen++;
        n_cmp++;
        if (exp_done.size() == 0) begin
          n_fail++; $display("FAIL frame_done_extra: count=%0d, none expected", frame_count);
        end else begin
          ef = exp_done.pop_front();
          if (frame_count !== ef || frame_words != H*V) begin
            n_fail++;
            $display("FAIL frame_done: count=%0d words=%0d, required count=%0d words=%0d",
                     frame_count, frame_words, ef, H*V);
          end
        end
        frame_words = 0;
      end
      if (late_frame) late_seen++;
      if (fifo_wr_en) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_fail++; $display("FAIL word_extra: data=%h, none expected", fifo_wr_data);
        end else begin
          ed = exp_data.pop_front();
          if (fifo_wr_data !== ed) begin
            n_fail++; $display("FAIL word_data: got %h, required %h", fifo_wr_data, ed);
          end
        end
        frame_words++; level++; out_model--;
      end
      if (fu_mode == 2 && level > 0 && $urandom_range(1, 0) == 1) level--;
      if (level > max_level) max_level = level;

      m_waitrequest = wr_rand ? ($urandom_range(2, 0) == 0) : 1'b0;
      if (m_read && !m_waitrequest) begin
        acc_cnt++;
        n_cmp++;
        if (exp_burst.size() == 0) begin
          n_fail++; $display("FAIL burst_extra: addr=%h len=%0d, none expected", m_address, m_burstcount);
        end else begin
          eb = exp_burst.pop_front();
          if (m_address !== eb.addr || m_burstcount !== eb.len) begin
            n_fail++;
            $display("FAIL burst: addr=%h len=%0d, required addr=%h len=%0d",
                     m_address, m_burstcount, eb.addr, eb.len);
          end
        end
        for (int k = 0; k < int'(m_burstcount); k++) begin
          w.due  = cyc + lat;
          w.data = (m_address + 32'(4*k)) ^ 32'h5A5A_0000;
          rd_q.push_back(w);
          exp_data.push_back(w.data);
        end
        out_model += int'(m_burstcount);
        if (out_model > max_out) max_out = out_model;
      end
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        w = rd_q.pop_front();
        m_readdatavalid = 1'b1; m_readdata = w.data;
      end else begin
        m_readdatavalid = 1'b0; m_readdata = '0;
      end
    end
  end

  task automatic push_frame(input logic [31:0] base, input logic [15:0] strd, input int fc);
    logic [31:0] lb;
    burst_t b;
    lb = base;
    for (int l = 0; l < V; l++) begin
      for (int wi = 0; wi < H; wi += BM) begin
        b.addr = lb + 32'(4*wi);
        b.len  = 8'((H - wi < BM) ? (H - wi) : BM);
        exp_burst.push_back(b);
      end
      lb = lb + {16'h0000, strd};
    end
    exp_done.push_back(16'(fc));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk); vsync_edge = 1'b1;
    @(negedge clk); vsync_edge = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++; $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_seen < target && k < budget) begin
      @(negedge clk); k++;
    end
    check("frame_wait", 64'(done_seen >= target), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int want, acc0, late0, k;
    want = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {m_read, m_address, m_burstcount, busy, frame_done, late_frame, frame_count, fifo_wr_en},
          '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single frame, first read one cycle after vsync
    cfg_continuous = 1'b0; cfg_base_addr = 32'h0000_1000; cfg_stride = 16'h0100;
    push_frame(32'h0000_1000, 16'h0100, 1);
    pulse_start();
    pulse_vsync();
    check("first_read_latency", 64'(m_read), 64'd1);
    want++; wait_done(want, 2000);

    // 2: address wrap across 32 bits, 8/8/4 split per line
    cfg_base_addr = 32'hFFFF_FF00; cfg_stride = 16'h0080;
    push_frame(32'hFFFF_FF00, 16'h0080, 2);
    pulse_start(); pulse_vsync();
    want++; wait_done(want, 2000);

    // 3: credit boundary at 505/504, stride 0 repeats line 0
    cfg_base_addr = 32'h0000_2000; cfg_stride = 16'h0000;
    fu_force = 9'd505; fu_mode = 1;
    push_frame(32'h0000_2000, 16'h0000, 3);
    acc0 = acc_cnt;
    pulse_start(); pulse_vsync();
    repeat (20) @(negedge clk);
    check("credit_block_read", 64'(m_read), 64'd0);
    check("credit_block_acc", 64'(acc_cnt - acc0), 64'd0);
    fu_force = 9'd504;
    @(negedge clk);
    check("credit_release_read", 64'(m_read), 64'd1);
    fu_mode = 0;
    want++; wait_done(want, 2000);

    // 4: continuous, random waitrequest, 10-cycle read latency, three frames
    wr_rand = 1'b1; lat = 10; fu_mode = 2; max_level = 0; max_out = 0;
    cfg_continuous = 1'b1; cfg_enable = 1'b1; cfg_stride = 16'h0050;
    for (int f = 0; f < 3; f++) begin
      cfg_base_addr = 32'h0001_0000 + 32'(f * 32'h1000);
      push_frame(32'h0001_0000 + 32'(f * 32'h1000), 16'h0050, 4 + f);
      repeat (3) @(negedge clk);
      pulse_vsync();
      want++; wait_done(want, 4000);
    end
    check("fifo_no_overflow", 64'(max_level <= FD), 64'd1);
    check("outstanding_bound", 64'(max_out <= FD), 64'd1);
    wr_rand = 1'b0; lat = 1; fu_mode = 0;

    // 5: vsync while busy -> one late pulse, frame continues, next on next vsync
    cfg_base_addr = 32'h0003_0000; cfg_stride = 16'h0200;
    push_frame(32'h0003_0000, 16'h0200, 7);
    late0 = late_seen; acc0 = acc_cnt;
    pulse_vsync();
    k = 0;
    while (acc_cnt < acc0 + 4 && k < 500) begin @(negedge clk); k++; end
    pulse_vsync();
    want++; wait_done(want, 2000);
    check("late_frame_once", 64'(late_seen - late0), 64'd1);
    acc0 = acc_cnt;
    repeat (10) @(negedge clk);
    check("no_start_without_vsync_busy", 64'(busy), 64'd0);
    check("no_start_without_vsync_acc", 64'(acc_cnt - acc0), 64'd0);
    push_frame(32'h0003_0000, 16'h0200, 8);
    pulse_vsync();
    cfg_enable = 1'b0;
    want++; wait_done(want, 2000);
    acc0 = acc_cnt;
    pulse_vsync();
    repeat (20) @(negedge clk);
    check("idle_ignores_vsync", 64'(acc_cnt - acc0), 64'd0);

    // 6: reset in the middle of a frame with three bursts in flight
    cfg_enable = 1'b1; cfg_continuous = 1'b0; lat = 10;
    cfg_base_addr = 32'h0004_0000; cfg_stride = 16'h0100;
    push_frame(32'h0004_0000, 16'h0100, 9);
    acc0 = acc_cnt;
    pulse_start(); pulse_vsync();
    k = 0;
    while (acc_cnt < acc0 + 3 && k < 500) begin @(negedge clk); k++; end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("reset_midframe_outputs",
          {m_read, m_address, m_burstcount, busy, frame_done, late_frame, frame_count, fifo_wr_en},
          '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    acc0 = acc_cnt;
    repeat (30) @(negedge clk);
    check("post_reset_idle_acc", 64'(acc_cnt - acc0), 64'd0);
    check("post_reset_idle_busy", 64'(busy), 64'd0);
    lat = 1;
    push_frame(32'h0004_0000, 16'h0100, 1);
    pulse_start(); pulse_vsync();
    want = done_seen + 1;
    wait_done(want, 2000);

    repeat (5) @(negedge clk);
    check("bursts_all_seen", 64'(exp_burst.size()), 64'd0);
    check("words_all_seen", 64'(exp_data.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
